// File: rtl/scratch_pad_pkg.sv
// Shared types and address-field positions for the scratch-pad ping-pong controller.
package scratch_pad_pkg;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_VALID
   } rd_state_t;

   // data_in_addr layout: {bank, bram_idx[6:0], half}
   localparam int BANK_BIT  = 8;
   localparam int IDX_MSB   = 7;
   localparam int IDX_LSB   = 1;
   localparam int HALF_BIT  = 0;
   localparam int NUM_BANKS = 2;

endpackage

// File: rtl/spc_read_seq.sv
// Read-side sequencer: selects the full bank, waits out the BRAM read latency,
// then holds tile_valid until the consumer releases the bank.
module spc_read_seq
   import scratch_pad_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] bank_full,
   input  logic       tile_done,
   output logic       rbank,
   output logic       data_out_addr,
   output logic       tile_valid,
   output logic       clr
);

   localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

   rd_state_t  state;
   rd_state_t  state_nxt;
   logic [2:0] lat_cnt;
   logic       start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= R_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (bank_full[rbank]) state_nxt = R_WAIT;
         R_WAIT:  if (lat_cnt == 3'd0)  state_nxt = R_VALID;
         R_VALID: if (tile_done)        state_nxt = R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      tile_valid = (state == R_VALID);
      clr        = (state == R_VALID) && tile_done;
      start      = (state == R_IDLE) && bank_full[rbank];
   end

   // The read address is committed one latency window before tile_valid rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rbank         <= 1'b0;
         data_out_addr <= 1'b0;
         lat_cnt       <= 3'd0;
      end else begin
         if (start) begin
            data_out_addr <= rbank;
            lat_cnt       <= LAT_INIT;
         end else if ((state == R_WAIT) && (lat_cnt != 3'd0)) begin
            lat_cnt <= lat_cnt - 3'd1;
         end
         if (clr) rbank <= ~rbank;
      end
   end

endmodule

// File: rtl/scratch_pad_ctrl.sv
// Ping-pong load/read controller for the two-bank scratch pad.
// Optional tile-framing check enabled by defining SCRATCH_PAD_CTRL_LAST_CHECK_EN (adds in_last).
module scratch_pad_ctrl
   import scratch_pad_pkg::*;
#(
   parameter int NUM_BRAM = 65,
   parameter int RD_LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
   input  logic        in_last,
`endif
   output logic        wen,
   output logic [8:0]  data_in_addr,
   output logic [31:0] data_in,
   output logic        data_out_addr,
   output logic        tile_valid,
   input  logic        tile_done,
   output logic [1:0]  bank_full,
   output logic        err
);

   localparam int         WORDS    = 2 * NUM_BRAM;
   localparam logic [7:0] LAST_CNT = 8'(WORDS - 1);

   logic       wbank;
   logic [7:0] wcnt;
   logic       hs;
   logic       tile_end;
   logic       close_pend;
   logic       close_bank;
   logic       rbank;
   logic       clr;
   logic [1:0] set_vec;
   logic [1:0] clr_vec;

   assign in_ready = !bank_full[wbank] && !rst;
   assign hs       = in_valid && in_ready;
   assign tile_end = hs && (wcnt == LAST_CNT);

   always_comb begin
      set_vec = close_pend ? (2'b01 << close_bank) : 2'b00;
      clr_vec = clr ? (2'b01 << rbank) : 2'b00;
   end

   // Write stage: accepted word appears on the scratch-pad port one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen          <= 1'b0;
         data_in_addr <= 9'd0;
         data_in      <= 32'd0;
         wbank        <= 1'b0;
         wcnt         <= 8'd0;
      end else begin
         wen <= hs;
         if (hs) begin
            data_in_addr <= {wbank, wcnt[IDX_MSB:IDX_LSB], wcnt[HALF_BIT]};
            data_in      <= in_data;
            if (tile_end) begin
               wcnt  <= 8'd0;
               wbank <= ~wbank;
            end else begin
               wcnt <= wcnt + 8'd1;
            end
         end
      end
   end

   // Full flag lags the last write by one cycle so the BRAM write lands before any read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         close_pend <= 1'b0;
         close_bank <= 1'b0;
         bank_full  <= 2'b00;
      end else begin
         close_pend <= tile_end;
         if (tile_end) close_bank <= wbank;
         bank_full <= (bank_full | set_vec) & ~clr_vec;
      end
   end

`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         err <= 1'b0;
      else if (hs && (in_last != (wcnt == LAST_CNT)))  err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

   spc_read_seq #(
      .RD_LAT (RD_LAT)
   ) u_read_seq (
      .clk           (clk),
      .rst           (rst),
      .bank_full     (bank_full),
      .tile_done     (tile_done),
      .rbank         (rbank),
      .data_out_addr (data_out_addr),
      .tile_valid    (tile_valid),
      .clr           (clr)
   );

endmodule

// File: tb/tb_scratch_pad_ctrl.sv
// Self-checking bench for scratch_pad_ctrl: directed ping-pong scenarios plus random
// traffic against a tile-level reference model. Covers SCRATCH_PAD_CTRL_LAST_CHECK_EN when defined.
module tb_scratch_pad_ctrl;

   localparam int NUM_BRAM = 65;
   localparam int RD_LAT   = 2;
   localparam int WORDS    = 2 * NUM_BRAM;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        in_valid  = 1'b0;
   logic [31:0] in_data   = 32'd0;
   logic        tile_done = 1'b0;
   logic        in_ready;
   logic        wen;
   logic [8:0]  data_in_addr;
   logic [31:0] data_in;
   logic        data_out_addr;
   logic        tile_valid;
   logic [1:0]  bank_full;
   logic        err;
`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
   logic        in_last = 1'b0;
`endif
   logic        inject = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   scratch_pad_ctrl #(
      .NUM_BRAM (NUM_BRAM),
      .RD_LAT   (RD_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
      .in_last       (in_last),
`endif
      .wen           (wen),
      .data_in_addr  (data_in_addr),
      .data_in       (data_in),
      .data_out_addr (data_out_addr),
      .tile_valid    (tile_valid),
      .tile_done     (tile_done),
      .bank_full     (bank_full),
      .err           (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tile counts, full-flag due times and read-ready cycle numbers.
   int          cyc          = 0;
   logic        m_wbank      = 1'b0;
   int          m_wcnt       = 0;
   logic [1:0]  m_full       = 2'b00;
   int          full_due [2] = '{-1, -1};
   logic        m_rbank      = 1'b0;
   logic        m_doa        = 1'b0;
   int          m_valid_at   = -1;
   logic        m_wen        = 1'b0;
   logic [8:0]  m_addr       = 9'd0;
   logic [31:0] m_data       = 32'd0;
   logic        m_err        = 1'b0;
   int          tiles_closed = 0;
   int          tiles_read   = 0;

   always @(posedge clk or posedge rst) begin : model
      logic hs;
      logic tv_before;
      if (rst) begin
         cyc        = 0;
         m_wbank    = 1'b0;
         m_wcnt     = 0;
         m_full     = 2'b00;
         full_due   = '{-1, -1};
         m_rbank    = 1'b0;
         m_doa      = 1'b0;
         m_valid_at = -1;
         m_wen      = 1'b0;
         m_addr     = 9'd0;
         m_data     = 32'd0;
         m_err      = 1'b0;
      end else begin
         tv_before = (m_valid_at >= 0) && (cyc >= m_valid_at);
         hs        = in_valid && !m_full[m_wbank];
         cyc++;
         m_wen = hs;
         if (hs) begin
            m_addr = {m_wbank, 8'(m_wcnt)};
            m_data = in_data;
`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
            if (in_last != (m_wcnt == WORDS - 1)) m_err = 1'b1;
`endif
            if (m_wcnt == WORDS - 1) begin
               m_wcnt            = 0;
               full_due[m_wbank] = cyc + 1;
               m_wbank           = !m_wbank;
               tiles_closed++;
            end else begin
               m_wcnt++;
            end
         end
         if (tile_done && tv_before) begin
            m_full[m_rbank] = 1'b0;
            m_rbank         = !m_rbank;
            m_valid_at      = -1;
            tiles_read++;
         end
         for (int b = 0; b < 2; b++) begin
            if (full_due[b] == cyc) begin
               m_full[b]   = 1'b1;
               full_due[b] = -1;
            end
         end
         if ((m_valid_at >= 0) && (cyc == m_valid_at - RD_LAT)) m_doa = m_rbank;
         if ((m_valid_at < 0) && m_full[m_rbank]) m_valid_at = cyc + 1 + RD_LAT;
      end
   end

   always @(negedge clk) begin : compare
      logic exp_tv;
      exp_tv = (m_valid_at >= 0) && (cyc >= m_valid_at);
      chk("in_ready", in_ready, rst ? 1'b0 : !m_full[m_wbank]);
      chk("wen", wen, m_wen);
      if (m_wen || rst) begin
         chk("data_in_addr", data_in_addr, m_addr);
         chk("data_in", data_in, m_data);
      end
      chk("bank_full", bank_full, m_full);
      chk("tile_valid", tile_valid, exp_tv);
      chk("data_out_addr", data_out_addr, m_doa);
      chk("err", err, m_err);
      if (tile_valid === 1'b1) chk("read_bank_is_full", bank_full[data_out_addr], 1'b1);
   end

   task automatic step();
      @(negedge clk);
      #1;
`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
      in_last = (m_wcnt == WORDS - 1) || (inject && (m_wcnt == 10));
`endif
   endtask

   initial begin : stim
      int n;
      int guard;
      logic reached;

      repeat (3) step();
      rst = 1'b0;

      // Tile 0 streamed back-to-back into bank 0
      inject   = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      n        = 0;
      guard    = 0;
      while (n < WORDS && guard < 1000) begin
         step();
         in_data = $urandom;
         if (wen) begin
            if (n == 0) chk("first_addr", data_in_addr, 9'h000);
            n++;
         end
         guard++;
      end
      inject = 1'b0;
      chk("tile0_words", n, WORDS);
      chk("tile0_last_wen", wen, 1'b1);
      chk("tile0_last_addr", data_in_addr, 9'h081);
      step(); in_data = $urandom;
      chk("full_after_tile0", bank_full, 2'b01);
      chk("tv_f0", tile_valid, 1'b0);
      step(); in_data = $urandom;
      chk("tv_f1", tile_valid, 1'b0);
      step(); in_data = $urandom;
      chk("tv_f2", tile_valid, 1'b0);
      step(); in_data = $urandom;
      chk("tv_f3", tile_valid, 1'b1);
      chk("doa_tile0", data_out_addr, 1'b0);
`ifdef SCRATCH_PAD_CTRL_LAST_CHECK_EN
      chk("err_sticky", err, 1'b1);
`endif

      // Tile 1 fills bank 1, then the writer stalls with both banks full
      guard = 0;
      while (bank_full != 2'b11 && guard < 400) begin
         step();
         in_data = $urandom;
         guard++;
      end
      chk("both_full", bank_full, 2'b11);
      repeat (4) begin
         step();
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_wen", wen, 1'b0);
      end

      // Release bank 0 while both are full
      tile_done = 1'b1;
      step();
      tile_done = 1'b0;
      chk("release_full", bank_full, 2'b10);
      chk("release_in_ready", in_ready, 1'b1);
      chk("release_tv", tile_valid, 1'b0);
      step(); in_data = $urandom;
      chk("resume_wen", wen, 1'b1);
      chk("resume_addr", data_in_addr, 9'h000);
      chk("reload_tv1", tile_valid, 1'b0);
      step(); in_data = $urandom;
      chk("reload_tv2", tile_valid, 1'b0);
      step(); in_data = $urandom;
      chk("reload_tv3", tile_valid, 1'b1);
      chk("reload_doa", data_out_addr, 1'b1);

      // Reset in the middle of a tile
      reached = 1'b0;
      guard   = 0;
      while (!reached && guard < 200) begin
         step();
         in_data = $urandom;
         if (wen && data_in_addr == 9'h031) reached = 1'b1;
         guard++;
      end
      chk("mid_tile_reached", reached, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_wen", wen, 1'b0);
      chk("rst_addr", data_in_addr, 9'h000);
      chk("rst_data", data_in, 32'd0);
      chk("rst_full", bank_full, 2'b00);
      chk("rst_tv", tile_valid, 1'b0);
      chk("rst_doa", data_out_addr, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_err", err, 1'b0);
      repeat (2) step();
      rst = 1'b0;
      guard = 0;
      while (!wen && guard < 20) begin
         step();
         in_data = $urandom;
         guard++;
      end
      chk("restart_wen", wen, 1'b1);
      chk("restart_addr", data_in_addr, 9'h000);

      // Random valid gaps and release delays over at least 20 read tiles
      tiles_read   = 0;
      tiles_closed = 0;
      guard        = 0;
      while (tiles_read < 20 && guard < 20000) begin
         step();
         in_valid  = ($urandom % 10) < 7;
         in_data   = $urandom;
         tile_done = ($urandom % 4) == 0;
         guard++;
      end
      tile_done = 1'b0;
      in_valid  = 1'b0;
      chk("random_tiles_read", tiles_read >= 20, 1'b1);
      chk("random_tiles_closed", tiles_closed >= tiles_read, 1'b1);
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
